// File: rtl/id_stage_param.sv
// Instruction-decode stage: register file with write-through bypass,
// operand forwarding, immediate generation, signed compare, load-use
// hazard detection and the ID/EX pipeline register.
module id_stage_param #(
    parameter int DATA_W   = 16,
    parameter int IMM_W    = 8,
    parameter int LINK_REG = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [15:0]       instr,
    input  logic [DATA_W-1:0] npc,
    input  logic [4:0]        ctrl,
    input  logic              stall_in,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [2:0]        wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [1:0]        fwd_a,
    input  logic [1:0]        fwd_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              ex_is_load,
    input  logic [2:0]        ex_rd,
    output logic [2:0]        ra,
    output logic [2:0]        rb,
    output logic              hazard_stall,
    output logic              out_valid,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] imm_out,
    output logic [DATA_W-1:0] i_imm,
    output logic [DATA_W-1:0] j_imm,
    output logic [DATA_W-1:0] ret_addr,
    output logic [2:0]        rd_out,
    output logic              gt,
    output logic              lt,
    output logic              eq,
    output logic [15:0]       bubble_cnt
);
    localparam logic [2:0] LINK_IDX = 3'(LINK_REG);

    logic src1_zero, src2_sel, regdst_link, ext_signed, ext_place;
    assign {src1_zero, src2_sel, regdst_link, ext_signed, ext_place} = ctrl;

    // Opcode bits above the register fields are decoded elsewhere.
    logic unused_bits;
    assign unused_bits = ^instr[15:12];

    logic [7:0][DATA_W-1:0] regs;
    logic [DATA_W-1:0]      ra_val, rb_val, link_val;
    logic [DATA_W-1:0]      op_a, op_b;
    logic [IMM_W-1:0]       imm_field;
    logic [DATA_W-1:0]      ext_imm;
    logic                   bubble;

    assign ra = src1_zero ? 3'd0 : instr[8:6];
    assign rb = src2_sel ? instr[5:3] : instr[11:9];

    // Reads see a same-cycle writeback so the writer and reader need no extra stall.
    assign ra_val   = (ra == 3'd0) ? '0 : (wb_en && wb_rd == ra) ? wb_data : regs[ra];
    assign rb_val   = (rb == 3'd0) ? '0 : (wb_en && wb_rd == rb) ? wb_data : regs[rb];
    assign link_val = (LINK_IDX == 3'd0) ? '0 :
                      (wb_en && wb_rd == LINK_IDX) ? wb_data : regs[LINK_IDX];

    // Operand selection between regfile and the later-stage forwarding paths.
    always_comb begin
        op_a = ra_val;
        op_b = rb_val;
        case (fwd_a)
            2'd1:    op_a = alu_result;
            2'd2:    op_a = mem_result;
            2'd3:    op_a = wb_data;
            default: op_a = ra_val;
        endcase
        case (fwd_b)
            2'd1:    op_b = alu_result;
            2'd2:    op_b = mem_result;
            2'd3:    op_b = wb_data;
            default: op_b = rb_val;
        endcase
    end

    // Immediate: upper placement (lui-style) or low-bit sign/zero extension.
    always_comb begin
        imm_field = instr[IMM_W-1:0];
        if (ext_place)
            ext_imm = {imm_field, {(DATA_W-IMM_W){1'b0}}};
        else if (ext_signed)
            ext_imm = {{(DATA_W-IMM_W){imm_field[IMM_W-1]}}, imm_field};
        else
            ext_imm = {{(DATA_W-IMM_W){1'b0}}, imm_field};
    end

    // Load-use hazard: the instruction in EX produces a register we read now.
    assign hazard_stall = in_valid & ex_is_load & (ex_rd != 3'd0) &
                          ((ex_rd == ra) | (ex_rd == rb));

    assign bubble = !flush && !stall_in && hazard_stall;

    // Register file; writes are independent of pipeline control.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            regs <= '0;
        else if (wb_en && wb_rd != 3'd0)
            regs[wb_rd] <= wb_data;
    end

    // ID/EX register: flush > stall > hazard bubble > normal capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            a_out     <= '0;
            b_out     <= '0;
            pc_out    <= '0;
            imm_out   <= '0;
            i_imm     <= '0;
            j_imm     <= '0;
            ret_addr  <= '0;
            rd_out    <= '0;
            gt        <= 1'b0;
            lt        <= 1'b0;
            eq        <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            rd_out    <= '0;
        end else if (stall_in) begin
            out_valid <= out_valid;
        end else if (hazard_stall) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            a_out     <= op_a;
            b_out     <= op_b;
            pc_out    <= npc;
            imm_out   <= ext_imm;
            i_imm     <= npc + ext_imm;
            j_imm     <= {npc[DATA_W-1:12], instr[11:0]};
            ret_addr  <= link_val;
            rd_out    <= regdst_link ? LINK_IDX : instr[11:9];
            gt        <= $signed(op_a) > $signed(op_b);
            lt        <= $signed(op_a) < $signed(op_b);
            eq        <= op_a == op_b;
        end
    end

    // Saturating count of inserted load-use bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bubble_cnt <= '0;
        else if (bubble && bubble_cnt != 16'hFFFF)
            bubble_cnt <= bubble_cnt + 16'd1;
    end
endmodule
